// File: rtl/pdm_capture_ctrl.sv
// -----------------------------------------------------------------------------
// pdm_capture_ctrl
//
// Purpose:
//   Sequences one PDM microphone capture. While idle the PDM clock generator
//   is held in reset. On an accepted start the generator is released and the
//   microphone wake-up period (WAKE_CYCLES mic-clock rising strobes) is
//   discarded. After that, one PDM bit is sampled on every rising strobe and
//   packed MSB-first into WORD_W-bit words. num_words words are offered on an
//   AXI-Stream-style output. A completed word that cannot be handed over
//   because the previous one is still stalled is dropped and flagged in the
//   sticky overflow bit. The controller then drains the output and returns to
//   idle with a one-cycle done pulse.
//
// Ports:
//   clk, rst     system clock; synchronous active-high reset
//   start        one-cycle capture request (only honoured when idle)
//   stop         abort request (honoured during wake-up and capture)
//   num_words    number of words to capture, latched on accepted start
//   busy         high whenever the controller is not idle
//   done         one-cycle pulse on return to idle
//   gen_rst      reset to the PDM clock generator (1 = hold in reset)
//   clk_rising   generator strobe, one cycle per mic-clock rising edge
//   pdm_data     synchronised microphone data bit
//   m_tdata      packed word, first captured bit in the MSB
//   m_tvalid     word valid
//   m_tready     downstream accept
//   m_tlast      marks the final word (index num_words-1)
//   overflow     sticky: a word was dropped due to backpressure
// -----------------------------------------------------------------------------
module pdm_capture_ctrl #(
    parameter int WORD_W      = 16,
    parameter int WAKE_CYCLES = 1024,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [CNT_W-1:0]  num_words,
    output logic              busy,
    output logic              done,
    output logic              gen_rst,
    input  logic              clk_rising,
    input  logic              pdm_data,
    output logic [WORD_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              overflow
);

    localparam int BIT_W  = $clog2(WORD_W);
    localparam int WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_W - 1);
    localparam logic [WAKE_W-1:0] LAST_WAKE = WAKE_W'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAKE,
        S_CAPTURE,
        S_FLUSH
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [CNT_W-1:0]    r_num_words, w_num_words_nxt;
    logic [WAKE_W-1:0]   r_wake_cnt,  w_wake_cnt_nxt;
    logic [BIT_W-1:0]    r_bit_cnt,   w_bit_cnt_nxt;
    logic [CNT_W-1:0]    r_word_cnt,  w_word_cnt_nxt;
    logic [WORD_W-1:0]   r_sr,        w_sr_nxt;
    logic [WORD_W-1:0]   r_tdata,     w_tdata_nxt;
    logic                r_tvalid,    w_tvalid_nxt;
    logic                r_tlast,     w_tlast_nxt;
    logic                r_overflow,  w_overflow_nxt;
    logic                r_busy,      w_busy_nxt;
    logic                r_done,      w_done_nxt;
    logic                r_gen_rst,   w_gen_rst_nxt;

    logic [WORD_W-1:0]   w_sr_shift;
    logic                w_last_word;
    logic                w_can_load;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, datapath and registered-output computation. The output
    // stage is updated from the next state, so busy/gen_rst change in the
    // same cycle the new state becomes visible.
    always_comb begin
        w_state_nxt     = r_state;
        w_num_words_nxt = r_num_words;
        w_wake_cnt_nxt  = r_wake_cnt;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_word_cnt_nxt  = r_word_cnt;
        w_sr_nxt        = r_sr;
        w_tdata_nxt     = r_tdata;
        w_tvalid_nxt    = r_tvalid;
        w_tlast_nxt     = r_tlast;
        w_overflow_nxt  = r_overflow;
        w_done_nxt      = 1'b0;

        w_sr_shift  = {r_sr[WORD_W-2:0], pdm_data};
        w_last_word = (r_word_cnt == (r_num_words - CNT_W'(1)));
        w_can_load  = !r_tvalid || m_tready;

        // A handshake empties the output slot; a word loaded this same
        // cycle below overrides this.
        if (r_tvalid && m_tready) begin
            w_tvalid_nxt = 1'b0;
            w_tlast_nxt  = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (num_words != '0) begin
                        w_state_nxt     = S_WAKE;
                        w_num_words_nxt = num_words;
                        w_wake_cnt_nxt  = '0;
                        w_bit_cnt_nxt   = '0;
                        w_word_cnt_nxt  = '0;
                        w_overflow_nxt  = 1'b0;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end

            S_WAKE: begin
                if (stop) begin
                    w_state_nxt = S_FLUSH;
                end else if (clk_rising) begin
                    if (r_wake_cnt == LAST_WAKE) begin
                        w_state_nxt = S_CAPTURE;
                    end else begin
                        w_wake_cnt_nxt = r_wake_cnt + WAKE_W'(1);
                    end
                end
            end

            // Stop takes priority over a word completing on the same strobe,
            // so that word is discarded along with any partial bits.
            S_CAPTURE: begin
                if (stop) begin
                    w_state_nxt   = S_FLUSH;
                    w_bit_cnt_nxt = '0;
                end else if (clk_rising) begin
                    w_sr_nxt = w_sr_shift;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_bit_cnt_nxt  = '0;
                        w_word_cnt_nxt = r_word_cnt + CNT_W'(1);
                        if (w_can_load) begin
                            w_tdata_nxt  = w_sr_shift;
                            w_tvalid_nxt = 1'b1;
                            w_tlast_nxt  = w_last_word;
                        end else begin
                            w_overflow_nxt = 1'b1;
                        end
                        if (w_last_word) begin
                            w_state_nxt = S_FLUSH;
                        end
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
                    end
                end
            end

            // Leave as soon as the output slot is empty or is being emptied.
            S_FLUSH: begin
                if (w_can_load) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt    = (w_state_nxt != S_IDLE);
        w_gen_rst_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_FLUSH);
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_num_words <= '0;
            r_wake_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_word_cnt  <= '0;
            r_sr        <= '0;
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_overflow  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_gen_rst   <= 1'b1;
        end else begin
            r_num_words <= w_num_words_nxt;
            r_wake_cnt  <= w_wake_cnt_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_word_cnt  <= w_word_cnt_nxt;
            r_sr        <= w_sr_nxt;
            r_tdata     <= w_tdata_nxt;
            r_tvalid    <= w_tvalid_nxt;
            r_tlast     <= w_tlast_nxt;
            r_overflow  <= w_overflow_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_gen_rst   <= w_gen_rst_nxt;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign gen_rst  = r_gen_rst;
    assign m_tdata  = r_tdata;
    assign m_tvalid = r_tvalid;
    assign m_tlast  = r_tlast;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pdm_capture_ctrl
//
// Bench for pdm_capture_ctrl with WORD_W=8, WAKE_CYCLES=4. A strobe process
// emits clk_rising every 40 clocks; the first four strobes of a run carry 1s
// and the rest follow the repeating pattern 10110010, so every captured word
// should read 0xB2 and any wake bit leaking into a word would corrupt it.
// Expected words {tlast, data} are queued by each scenario and popped by an
// output monitor on every handshake.
// -----------------------------------------------------------------------------
module tb_pdm_capture_ctrl;

    localparam int WORD_W      = 8;
    localparam int WAKE_CYCLES = 4;
    localparam int CNT_W       = 16;
    localparam int STROBE_DIV  = 40;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [CNT_W-1:0]  num_words = '0;
    logic              busy;
    logic              done;
    logic              gen_rst;
    logic              clk_rising = 1'b0;
    logic              pdm_data = 1'b0;
    logic [WORD_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tready = 1'b0;
    logic              m_tlast;
    logic              overflow;

    int nChecks = 0;
    int nPass   = 0;
    int cycleNo = 0;
    int lastAccCycle = -1;

    logic [WORD_W:0] expQ[$];

    logic strobeEn  = 1'b0;
    int   strobeIdx = 0;
    int   strobeDiv = 0;
    logic [7:0] pat = 8'hB2;

    pdm_capture_ctrl #(
        .WORD_W      (WORD_W),
        .WAKE_CYCLES (WAKE_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .num_words  (num_words),
        .busy       (busy),
        .done       (done),
        .gen_rst    (gen_rst),
        .clk_rising (clk_rising),
        .pdm_data   (pdm_data),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .overflow   (overflow)
    );

    // 10 ns system clock.
    always #5 clk = ~clk;

    always @(posedge clk) cycleNo++;

    // Mic-clock strobe source with the data bit for each strobe.
    always begin
        @(posedge clk);
        #1;
        if (strobeEn) begin
            if (strobeDiv == STROBE_DIV - 1) begin
                strobeDiv  = 0;
                clk_rising = 1'b1;
                if (strobeIdx < WAKE_CYCLES)
                    pdm_data = 1'b1;
                else
                    pdm_data = pat[7 - ((strobeIdx - WAKE_CYCLES) % 8)];
                strobeIdx++;
            end else begin
                strobeDiv++;
                clk_rising = 1'b0;
            end
        end else begin
            strobeDiv  = 0;
            strobeIdx  = 0;
            clk_rising = 1'b0;
        end
    end

    // Output monitor: inputs only change just after posedge, so a handshake
    // visible at negedge is exactly the one taken on the next posedge.
    always @(negedge clk) begin
        if (!rst && m_tvalid && m_tready) begin
            lastAccCycle = cycleNo;
            nChecks++;
            if (expQ.size() == 0) begin
                $display("[TB] FAIL unexpected_word: got data=%h last=%b, required no word",
                         m_tdata, m_tlast);
            end else begin
                logic [WORD_W:0] exp;
                exp = expQ.pop_front();
                if ({m_tlast, m_tdata} !== exp)
                    $display("[TB] FAIL word: got last=%b data=%h, required last=%b data=%h",
                             m_tlast, m_tdata, exp[WORD_W], exp[WORD_W-1:0]);
                else
                    nPass++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStart(input int n);
        num_words = CNT_W'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(input string name, input int limit);
        int k;
        k = 0;
        while (done !== 1'b1 && k < limit) begin
            tick();
            k++;
        end
        nChecks++;
        if (done !== 1'b1)
            $display("[TB] FAIL %s_done_timeout: done=%b after %0d cycles, required 1", name, done, k);
        else
            nPass++;
    endtask

    task automatic waitStrobes(input int n, input int limit);
        int k;
        k = 0;
        while (strobeIdx < n && k < limit) begin
            tick();
            k++;
        end
        nChecks++;
        if (strobeIdx < n)
            $display("[TB] FAIL strobe_timeout: got %0d strobes, required %0d", strobeIdx, n);
        else
            nPass++;
    endtask

    task automatic test_reset(input string name);
        rst = 1'b1;
        tick();
        tick();
        nChecks += 7;
        if (gen_rst !== 1'b1)  $display("[TB] FAIL %s_gen_rst: got %b, required 1", name, gen_rst);  else nPass++;
        if (busy !== 1'b0)     $display("[TB] FAIL %s_busy: got %b, required 0", name, busy);        else nPass++;
        if (done !== 1'b0)     $display("[TB] FAIL %s_done: got %b, required 0", name, done);        else nPass++;
        if (m_tvalid !== 1'b0) $display("[TB] FAIL %s_tvalid: got %b, required 0", name, m_tvalid); else nPass++;
        if (m_tlast !== 1'b0)  $display("[TB] FAIL %s_tlast: got %b, required 0", name, m_tlast);   else nPass++;
        if (overflow !== 1'b0) $display("[TB] FAIL %s_overflow: got %b, required 0", name, overflow); else nPass++;
        if (m_tdata !== '0)    $display("[TB] FAIL %s_tdata: got %h, required 00", name, m_tdata);   else nPass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_capture(input int n);
        m_tready = 1'b1;
        for (int i = 0; i < n; i++)
            expQ.push_back({(i == n - 1), 8'hB2});
        applyStart(n);
        strobeEn = 1'b1;
        nChecks += 2;
        if (busy !== 1'b1)    $display("[TB] FAIL cap_busy: got %b, required 1", busy);       else nPass++;
        if (gen_rst !== 1'b0) $display("[TB] FAIL cap_gen_rst: got %b, required 0", gen_rst); else nPass++;
        waitDone("cap", (WAKE_CYCLES + WORD_W * n) * STROBE_DIV + 200);
        strobeEn = 1'b0;
        nChecks += 5;
        if (cycleNo !== lastAccCycle + 1)
            $display("[TB] FAIL cap_done_latency: done at cycle %0d, required %0d", cycleNo, lastAccCycle + 1);
        else nPass++;
        if (busy !== 1'b0)      $display("[TB] FAIL cap_busy_end: got %b, required 0", busy);       else nPass++;
        if (gen_rst !== 1'b1)   $display("[TB] FAIL cap_gen_rst_end: got %b, required 1", gen_rst); else nPass++;
        if (overflow !== 1'b0)  $display("[TB] FAIL cap_overflow: got %b, required 0", overflow);   else nPass++;
        if (expQ.size() !== 0)  $display("[TB] FAIL cap_words_left: got %0d, required 0", expQ.size()); else nPass++;
        tick();
        nChecks++;
        if (done !== 1'b0) $display("[TB] FAIL cap_done_pulse: got %b, required 0", done); else nPass++;
    endtask

    task automatic test_backpressure();
        int k;
        m_tready = 1'b0;
        expQ.push_back({1'b0, 8'hB2});
        applyStart(3);
        strobeEn = 1'b1;
        k = 0;
        while (!(busy === 1'b1 && gen_rst === 1'b1) && k < 2000) begin
            tick();
            k++;
        end
        nChecks += 3;
        if (gen_rst !== 1'b1)  $display("[TB] FAIL bp_flush_reached: gen_rst=%b, required 1", gen_rst); else nPass++;
        if (overflow !== 1'b1) $display("[TB] FAIL bp_overflow: got %b, required 1", overflow); else nPass++;
        if (m_tvalid !== 1'b1) $display("[TB] FAIL bp_tvalid_held: got %b, required 1", m_tvalid); else nPass++;
        repeat (50) tick();
        nChecks++;
        if (busy !== 1'b1) $display("[TB] FAIL bp_flush_hold: busy=%b, required 1", busy); else nPass++;
        m_tready = 1'b1;
        waitDone("bp", 10);
        strobeEn = 1'b0;
        nChecks += 2;
        if (expQ.size() !== 0)  $display("[TB] FAIL bp_words_left: got %0d, required 0", expQ.size()); else nPass++;
        if (overflow !== 1'b1)  $display("[TB] FAIL bp_overflow_sticky: got %b, required 1", overflow); else nPass++;
        tick();
    endtask

    task automatic test_stop();
        m_tready = 1'b0;
        expQ.push_back({1'b0, 8'hB2});
        applyStart(3);
        strobeEn = 1'b1;
        waitStrobes(WAKE_CYCLES + WORD_W + 5, 2000);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        nChecks += 4;
        if (gen_rst !== 1'b1)  $display("[TB] FAIL stop_gen_rst: got %b, required 1", gen_rst);  else nPass++;
        if (busy !== 1'b1)     $display("[TB] FAIL stop_busy: got %b, required 1", busy);        else nPass++;
        if (m_tvalid !== 1'b1) $display("[TB] FAIL stop_tvalid: got %b, required 1", m_tvalid); else nPass++;
        if (m_tlast !== 1'b0)  $display("[TB] FAIL stop_tlast: got %b, required 0", m_tlast);   else nPass++;
        repeat (100) tick();
        m_tready = 1'b1;
        waitDone("stop", 10);
        strobeEn = 1'b0;
        repeat (20) tick();
        nChecks += 2;
        if (expQ.size() !== 0) $display("[TB] FAIL stop_words_left: got %0d, required 0", expQ.size()); else nPass++;
        if (m_tvalid !== 1'b0) $display("[TB] FAIL stop_no_partial: tvalid=%b, required 0", m_tvalid); else nPass++;
    endtask

    task automatic test_zero_words();
        applyStart(0);
        nChecks += 3;
        if (done !== 1'b1)    $display("[TB] FAIL zero_done: got %b, required 1", done);       else nPass++;
        if (busy !== 1'b0)    $display("[TB] FAIL zero_busy: got %b, required 0", busy);       else nPass++;
        if (gen_rst !== 1'b1) $display("[TB] FAIL zero_gen_rst: got %b, required 1", gen_rst); else nPass++;
        tick();
        nChecks += 2;
        if (done !== 1'b0)    $display("[TB] FAIL zero_done_once: got %b, required 0", done);  else nPass++;
        if (gen_rst !== 1'b1) $display("[TB] FAIL zero_gen_rst2: got %b, required 1", gen_rst); else nPass++;
    endtask

    task automatic test_back_to_back_start_and_rst();
        m_tready = 1'b1;
        expQ.push_back({1'b0, 8'hB2});
        applyStart(3);
        strobeEn = 1'b1;
        waitStrobes(WAKE_CYCLES + WORD_W + 2, 2000);
        applyStart(1);
        tick();
        applyStart(1);
        nChecks += 3;
        if (busy !== 1'b1)     $display("[TB] FAIL b2b_busy: got %b, required 1", busy);       else nPass++;
        if (gen_rst !== 1'b0)  $display("[TB] FAIL b2b_gen_rst: got %b, required 0", gen_rst); else nPass++;
        if (expQ.size() !== 0) $display("[TB] FAIL b2b_word0: got %0d queued, required 0", expQ.size()); else nPass++;
        waitStrobes(WAKE_CYCLES + WORD_W + 5, 2000);
        tick();
        strobeEn = 1'b0;
        test_reset("midrst");
        test_capture(2);
    endtask

    initial begin
        $display("[TB] start");
        test_reset("reset");
        test_capture(3);
        test_backpressure();
        test_stop();
        test_zero_words();
        test_back_to_back_start_and_rst();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
